conv_net: RTL and testbench
===========================

// Module: conv_net
// PURPOSE
//  3x3 convolution engine behind a Cypress FX2 slave FIFO and a Wishbone SDRAM port.
//  Per frame it reads 9 kernel words, then 9 patch words, from USB.
//  It computes their signed dot product and stores the 32-bit result in SDRAM.
//  It reads the result back and returns it to the host over USB.
// PARAMETERS
//  N_TAPS    9    taps per frame (3x3)
//  DW        16   USB word / tap width
//  N_SLOTS   120  SDRAM result slots, addressed 0..119
// PORTS
//  CLK        in   1      sole clock
//  rst_n      in   1      asynchronous, ACTIVE-HIGH reset (1 = reset despite the suffix)
//  FLAGA      in   1      EP2 OUT FIFO not empty (1 = data available)
//  FLAGD      in   1      EP6 IN FIFO full (1 = full, do not write)
//  FIFOADR    out  2      2'b00 = EP2 (read), 2'b10 = EP6 (write)
//  LED        out  4      last result[3:0]
//  pktend     out  1      active-low packet commit
//  SLWR       out  1      active-low FIFO write strobe
//  SLRD       out  1      active-low FIFO read strobe
//  SLOE       out  1      active-low FX2 output enable
//  IFCLK      out  1      interface clock, = CLK
//  FDATA      inout 16    FIFO data; driven only in S_USB_WR, else Z
//  cstate     out  4      current FSM state (debug)
//  KERNELS_d  out  144    kernel taps; tap i at [16i+15:16i]
//  PATCHES_d  out  144    patch taps, same packing
//  data_o     in   32     WB read data
//  stall_o    in   1      WB stall
//  sdram_ack  in   1      WB ack; may stay high while cyc_i is high
//  stb_i, we_i, cyc_i  out 1   WB strobe / write enable / cycle
//  sel_i      out  4      constant 4'hF
//  addr_i     out  32     {25'b0, slot[6:0]}
//  data_i     out  32     WB write data = result
// BEHAVIOUR
//  Reset values
//  - SLRD=SLWR=SLOE=pktend=1; FIFOADR=00; FDATA=Z.
//  - cyc/stb/we=0; addr_i=data_i=0; LED=0; cstate=0.
//  - Tap registers, accumulator and slot are all 0.
//  - Reset mid-operation: immediate return to S_IDLE; a WB cycle is abandoned (cyc drops asynchronously).
//  FSM (cstate encoding)
//  - 0 S_IDLE -> 1.
//  - 1 S_RD_KERNEL / 2 S_RD_PATCH: FIFOADR=00, SLOE=0.
//    - SLRD = ~FLAGA, combinational.
//    - FDATA is captured into tap[idx] on every edge with SLRD=0; idx increments.
//    - After the 9th word, go to the next state. FLAGA=0 stalls with no capture.
//  - 3 S_MAC: 9 cycles, acc += $signed(k_i)*$signed(p_i). 32-bit, wraps, acc cleared on entry.
//  - 4 S_WB_WR: cyc=stb=we=1, addr=slot, data_i=acc.
//    - Hold while stall_o or !sdram_ack.
//    - On the ack edge, drop cyc/stb/we for one cycle (5 S_WB_GAP).
//  - 6 S_WB_RD: cyc=stb=1, we=0, same addr.
//    - Latch data_o on the ack edge, drop cyc/stb, go to 7.
//  - 7 S_USB_WR: FIFOADR=10, SLOE=1, FDATA driven.
//    - Word0 = rd[15:0], word1 = rd[31:16].
//    - SLWR=0 for one cycle per word, only while FLAGD=0. FLAGD=1 stalls.
//  - 8 S_PKTEND: pktend=0 for one cycle.
//    - LED <= rd[3:0].
//    - slot <= (slot==119) ? 0 : slot+1.
//    - Go to S_IDLE.
//  - Any unused encoding -> S_IDLE.
//  Wishbone rules
//  - One transfer per cycle.
//  - cyc is never high for two consecutive transfers without a low cycle between them.
// STRUCTURE
//  - Shared package: state encodings, FIFOADR codes (EP2=2'b00, EP6=2'b10), N_TAPS, N_SLOTS.
//  - One sub-module, wb_single_master: the single-transfer WB handshake with done pulse and read-data latch.
// TESTING
//  - Bench sdram model: ack 4 cycles after stb, held until cyc drops; writes to mem[addr[6:0]].
//  - Bench USB model: FDATA = counter (0,1,2,...), incremented per edge with SLRD=0; FLAGA=1 from cycle 3; FLAGD=0.
//  - Stream 0..17:
//    - Required: KERNELS_d taps = 0..8, PATCHES_d taps = 9..17.
//    - acc = 528 (0x210); sdram[0] = 0x210.
//    - USB writes 0x0210 then 0x0000; pktend pulses once; LED = 0.
//  - FLAGA low for 5 cycles mid-kernel -> SLRD stays 1, idx frozen; resumes with no lost or duplicated word.
//  - Signed taps: kernel all 0xFFFF, patch all 0x0002 -> result 0xFFFFFFEE (-18).
//  - FLAGD=1 during S_USB_WR -> SLWR stays 1 until FLAGD=0; FDATA is Z outside S_USB_WR.
//  - 120 frames -> slots 0..119 written, frame 121 writes slot 0.
//  - rst_n pulsed high during S_WB_WR -> cyc_i drops at once; cstate=0; all outputs at reset values.

Source files
------------

// File: rtl/conv_net_pkg.sv
// Shared constants, state encoding and slot arithmetic for the conv_net engine.
package conv_net_pkg;

    localparam int N_TAPS  = 9;
    localparam int DW      = 16;
    localparam int N_SLOTS = 120;
    localparam int ACC_W   = 32;

    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_KERNEL = 4'd1,
        S_RD_PATCH  = 4'd2,
        S_MAC       = 4'd3,
        S_WB_WR     = 4'd4,
        S_WB_GAP    = 4'd5,
        S_WB_RD     = 4'd6,
        S_USB_WR    = 4'd7,
        S_PKTEND    = 4'd8
    } state_t;

    // Result slots form a ring of N_SLOTS entries.
    function automatic logic [6:0] next_slot(input logic [6:0] s);
        return (s == 7'(N_SLOTS - 1)) ? 7'd0 : s + 7'd1;
    endfunction

endpackage

// File: rtl/conv_net_wb.sv
// Single-transfer Wishbone master: request level in, done pulse out, read data latched.
module wb_single_master (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    input  logic [31:0] data_o,
    input  logic        stall_o,
    input  logic        ack,
    output logic        cyc_i,
    output logic        stb_i,
    output logic        we_i,
    output logic [3:0]  sel_i,
    output logic [31:0] addr_i,
    output logic [31:0] data_i,
    output logic        done,
    output logic [31:0] rdata
);

    assign cyc_i  = req;
    assign stb_i  = req;
    assign we_i   = req & wr;
    assign sel_i  = 4'hF;
    assign addr_i = adr;
    assign data_i = wdat;

    // A held ack only completes the transfer on a non-stalled cycle.
    assign done = req & ack & ~stall_o;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (done && !wr) begin
            rdata <= data_o;
        end
    end

endmodule

// File: rtl/conv_net.sv
// 3x3 signed convolution: taps in over FX2 slave FIFO, result via SDRAM and back to USB.
module conv_net
    import conv_net_pkg::*;
(
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   FLAGA,
    input  logic                   FLAGD,
    output logic [1:0]             FIFOADR,
    output logic [3:0]             LED,
    output logic                   pktend,
    output logic                   SLWR,
    output logic                   SLRD,
    output logic                   SLOE,
    output logic                   IFCLK,
    inout  wire  [DW-1:0]          FDATA,
    output logic [3:0]             cstate,
    output logic [N_TAPS*DW-1:0]   KERNELS_d,
    output logic [N_TAPS*DW-1:0]   PATCHES_d,
    input  logic [31:0]            data_o,
    input  logic                   stall_o,
    input  logic                   sdram_ack,
    output logic                   stb_i,
    output logic                   we_i,
    output logic                   cyc_i,
    output logic [3:0]             sel_i,
    output logic [31:0]            addr_i,
    output logic [31:0]            data_i
);

    localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);

    state_t               state, state_nx;
    logic signed [DW-1:0] kern  [N_TAPS];
    logic signed [DW-1:0] patch [N_TAPS];
    logic [3:0]           idx;
    logic signed [ACC_W-1:0] acc;
    logic [6:0]           slot;
    logic                 word_sel;
    logic [31:0]          rd_data;
    logic                 wb_req, wb_wr, wb_done;

    // Full-width signed product; the accumulator wraps at ACC_W bits.
    function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DW-1:0] k,
                                                         input logic signed [DW-1:0] p);
        logic signed [ACC_W-1:0] prod;
        prod = k * p;
        return prod;
    endfunction

    assign IFCLK  = CLK;
    assign cstate = state;
    assign FDATA  = (state == S_USB_WR) ? (word_sel ? rd_data[31:16] : rd_data[15:0])
                                        : {DW{1'bz}};

    for (genvar g = 0; g < N_TAPS; g++) begin : g_pack
        assign KERNELS_d[g*DW +: DW] = kern[g];
        assign PATCHES_d[g*DW +: DW] = patch[g];
    end

    always_comb begin
        state_nx = state;
        FIFOADR  = FIFOADR_EP2;
        SLOE     = 1'b1;
        SLRD     = 1'b1;
        SLWR     = 1'b1;
        pktend   = 1'b1;
        wb_req   = 1'b0;
        wb_wr    = 1'b0;
        case (state)
            S_IDLE: state_nx = S_RD_KERNEL;
            S_RD_KERNEL, S_RD_PATCH: begin
                SLOE = 1'b0;
                SLRD = ~FLAGA;
                if (FLAGA && idx == LAST_TAP)
                    state_nx = (state == S_RD_KERNEL) ? S_RD_PATCH : S_MAC;
            end
            S_MAC: if (idx == LAST_TAP) state_nx = S_WB_WR;
            S_WB_WR: begin
                wb_req = 1'b1;
                wb_wr  = 1'b1;
                if (wb_done) state_nx = S_WB_GAP;
            end
            S_WB_GAP: state_nx = S_WB_RD;
            S_WB_RD: begin
                wb_req = 1'b1;
                if (wb_done) state_nx = S_USB_WR;
            end
            S_USB_WR: begin
                FIFOADR = FIFOADR_EP6;
                SLWR    = FLAGD;
                if (!FLAGD && word_sel) state_nx = S_PKTEND;
            end
            S_PKTEND: begin
                pktend   = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge CLK or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            acc      <= '0;
            slot     <= '0;
            word_sel <= 1'b0;
            LED      <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                kern[i]  <= '0;
                patch[i] <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                S_RD_KERNEL: if (FLAGA) begin
                    kern[idx] <= FDATA;
                    idx       <= (idx == LAST_TAP) ? 4'd0 : idx + 4'd1;
                end
                S_RD_PATCH: if (FLAGA) begin
                    patch[idx] <= FDATA;
                    if (idx == LAST_TAP) begin
                        idx <= '0;
                        acc <= '0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_MAC: begin
                    acc <= acc + mac_term(kern[idx], patch[idx]);
                    idx <= (idx == LAST_TAP) ? 4'd0 : idx + 4'd1;
                end
                S_USB_WR: if (!FLAGD) word_sel <= ~word_sel;
                S_PKTEND: begin
                    LED  <= rd_data[3:0];
                    slot <= next_slot(slot);
                end
                default: ;
            endcase
        end
    end

    wb_single_master u_wb (
        .CLK     (CLK),
        .rst     (rst_n),
        .req     (wb_req),
        .wr      (wb_wr),
        .adr     ({25'b0, slot}),
        .wdat    (acc),
        .data_o  (data_o),
        .stall_o (stall_o),
        .ack     (sdram_ack),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .sel_i   (sel_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .done    (wb_done),
        .rdata   (rd_data)
    );

endmodule

// File: tb/tb_conv_net.sv
// Randomized bench for conv_net with FX2 FIFO and Wishbone SDRAM models and a dot-product reference.
module tb_conv_net;

    localparam int N_TAPS  = 9;
    localparam int N_SLOTS = 120;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         FLAGA;
    logic         FLAGD;
    wire  [15:0]  FDATA;
    logic [1:0]   FIFOADR;
    logic [3:0]   LED;
    logic         pktend, SLWR, SLRD, SLOE, IFCLK;
    logic [3:0]   cstate;
    logic [143:0] KERNELS_d, PATCHES_d;
    logic [31:0]  data_o;
    logic         stall_o;
    logic         sdram_ack;
    logic         stb_i, we_i, cyc_i;
    logic [3:0]   sel_i;
    logic [31:0]  addr_i, data_i;

    int checks = 0;
    int errors = 0;

    // USB model state
    logic [15:0] stream [0:4095];
    int          n_stream = 0;
    int          ptr = 0;
    bit          flaga_en = 1'b0;
    logic [15:0] usb_word;
    logic [15:0] out_words [0:4095];
    int          n_out = 0;
    int          pkt_count = 0;

    // SDRAM model state
    logic [31:0] mem [0:127] = '{default: 32'hDEADBEEF};
    int          ack_cnt = 0;
    bit          stall_rand = 1'b0;

    int exp_slot = 0;
    int frames_done = 0;

    conv_net dut (
        .CLK(CLK), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD), .FIFOADR(FIFOADR),
        .LED(LED), .pktend(pktend), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE), .IFCLK(IFCLK),
        .FDATA(FDATA), .cstate(cstate), .KERNELS_d(KERNELS_d), .PATCHES_d(PATCHES_d),
        .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack), .stb_i(stb_i),
        .we_i(we_i), .cyc_i(cyc_i), .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i)
    );

    always #5 CLK = ~CLK;

    always_comb usb_word = (ptr < n_stream) ? stream[ptr] : 16'h0000;
    assign FDATA  = (SLOE == 1'b0) ? usb_word : 16'bz;
    assign FLAGA  = flaga_en && (ptr < n_stream);
    assign data_o = mem[addr_i[6:0]];

    always @(posedge CLK) begin
        if (!SLRD) ptr <= ptr + 1;
        if (!SLWR) begin
            out_words[n_out] <= FDATA;
            n_out <= n_out + 1;
        end
        if (!pktend) pkt_count <= pkt_count + 1;
    end

    always @(posedge CLK) begin
        if (!cyc_i) begin
            sdram_ack <= 1'b0;
            ack_cnt   <= 0;
        end else if (stb_i && !sdram_ack) begin
            if (ack_cnt == 3) sdram_ack <= 1'b1;
            else              ack_cnt   <= ack_cnt + 1;
        end
        if (cyc_i && stb_i && we_i && sdram_ack && !stall_o) mem[addr_i[6:0]] <= data_i;
    end

    always @(negedge CLK) stall_o = stall_rand && ($urandom_range(0, 3) == 0);

    function automatic logic [31:0] ref_dot(input int base);
        longint s = 0;
        shortint k, p;
        for (int i = 0; i < N_TAPS; i++) begin
            k = shortint'(stream[base + i]);
            p = shortint'(stream[base + N_TAPS + i]);
            s += longint'(k) * longint'(p);
        end
        return s[31:0];
    endfunction

    task automatic push_word(input logic [15:0] w);
        stream[n_stream] = w;
        n_stream++;
    endtask

    task automatic push_random_frame();
        for (int i = 0; i < 2 * N_TAPS; i++) push_word(16'($urandom()));
    endtask

    task automatic run_and_check(input int base, input string tag);
        logic [31:0] exp_res;
        int out0, target;
        exp_res = ref_dot(base);
        out0    = n_out;
        target  = pkt_count + 1;
        for (int c = 0; c < 600; c++) begin
            if (pkt_count >= target) break;
            @(negedge CLK);
        end
        checks++;
        if (pkt_count !== target) begin
            errors++;
            $display("FAIL %s pktend_count got %0d want %0d", tag, pkt_count, target);
        end
        for (int i = 0; i < N_TAPS; i++) begin
            checks++;
            if (KERNELS_d[16*i +: 16] !== stream[base + i]) begin
                errors++;
                $display("FAIL %s kernel[%0d] got %h want %h", tag, i, KERNELS_d[16*i +: 16], stream[base + i]);
            end
            checks++;
            if (PATCHES_d[16*i +: 16] !== stream[base + N_TAPS + i]) begin
                errors++;
                $display("FAIL %s patch[%0d] got %h want %h", tag, i, PATCHES_d[16*i +: 16], stream[base + N_TAPS + i]);
            end
        end
        checks++;
        if (mem[exp_slot] !== exp_res) begin
            errors++;
            $display("FAIL %s sdram[%0d] got %h want %h", tag, exp_slot, mem[exp_slot], exp_res);
        end
        checks++;
        if (n_out !== out0 + 2) begin
            errors++;
            $display("FAIL %s usb_word_count got %0d want %0d", tag, n_out - out0, 2);
        end
        checks++;
        if (out_words[out0] !== exp_res[15:0]) begin
            errors++;
            $display("FAIL %s usb_word0 got %h want %h", tag, out_words[out0], exp_res[15:0]);
        end
        checks++;
        if (out_words[out0 + 1] !== exp_res[31:16]) begin
            errors++;
            $display("FAIL %s usb_word1 got %h want %h", tag, out_words[out0 + 1], exp_res[31:16]);
        end
        checks++;
        if (LED !== exp_res[3:0]) begin
            errors++;
            $display("FAIL %s led got %h want %h", tag, LED, exp_res[3:0]);
        end
        exp_slot = (exp_slot == N_SLOTS - 1) ? 0 : exp_slot + 1;
        frames_done++;
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [31:0] got, want;
        got  = {SLRD, SLWR, SLOE, pktend, FIFOADR, cyc_i, stb_i, we_i, LED, cstate, 13'd0};
        want = {4'b1111, 2'b00, 3'b000, 4'h0, 4'h0, 13'd0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s control_outputs got %h want %h", tag, got, want);
        end
        checks++;
        if (addr_i !== 32'h0 || data_i !== 32'h0) begin
            errors++;
            $display("FAIL %s wb_addr_data got %h/%h want 0/0", tag, addr_i, data_i);
        end
        checks++;
        if (KERNELS_d !== 144'h0 || PATCHES_d !== 144'h0) begin
            errors++;
            $display("FAIL %s taps got %h/%h want 0", tag, KERNELS_d, PATCHES_d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        FLAGD = 1'b0;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        checks++;
        if (sel_i !== 4'hF) begin
            errors++;
            $display("FAIL reset sel got %h want F", sel_i);
        end
        checks++;
        if (IFCLK !== CLK) begin
            errors++;
            $display("FAIL reset ifclk got %b want %b", IFCLK, CLK);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_stream();
        int base;
        base = n_stream;
        for (int i = 0; i < 2 * N_TAPS; i++) push_word(16'(i));
        repeat (3) @(negedge CLK);
        flaga_en = 1'b1;
        run_and_check(base, "stream");
        checks++;
        if (mem[0] !== 32'h0000_0210) begin
            errors++;
            $display("FAIL stream sdram0 got %h want 00000210", mem[0]);
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (pkt_count !== 1) begin
            errors++;
            $display("FAIL stream single_pktend got %0d want 1", pkt_count);
        end
    endtask

    task automatic test_flaga_stall();
        int base, saved;
        base = n_stream;
        push_random_frame();
        for (int c = 0; c < 100; c++) begin
            if (ptr >= base + 4) break;
            @(negedge CLK);
        end
        flaga_en = 1'b0;
        saved = ptr;
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if (SLRD !== 1'b1 || ptr !== saved || cstate !== 4'd1) begin
                errors++;
                $display("FAIL flaga_stall hold got slrd=%b ptr=%0d st=%0d want 1/%0d/1", SLRD, ptr, cstate, saved);
            end
        end
        flaga_en = 1'b1;
        run_and_check(base, "flaga_stall");
    endtask

    task automatic test_signed();
        int base;
        base = n_stream;
        for (int i = 0; i < N_TAPS; i++) push_word(16'hFFFF);
        for (int i = 0; i < N_TAPS; i++) push_word(16'h0002);
        run_and_check(base, "signed");
        checks++;
        if ({out_words[n_out - 1], out_words[n_out - 2]} !== 32'hFFFF_FFEE) begin
            errors++;
            $display("FAIL signed result got %h want FFFFFFEE", {out_words[n_out - 1], out_words[n_out - 2]});
        end
    endtask

    task automatic test_usb_stall();
        int base;
        logic [31:0] exp_res;
        base = n_stream;
        FLAGD = 1'b1;
        push_random_frame();
        exp_res = ref_dot(base);
        for (int c = 0; c < 300; c++) begin
            if (cstate == 4'd7) break;
            @(negedge CLK);
        end
        checks++;
        if (cstate !== 4'd7) begin
            errors++;
            $display("FAIL usb_stall reach_state got %0d want 7", cstate);
        end
        repeat (6) begin
            @(negedge CLK);
            checks++;
            if (SLWR !== 1'b1 || SLOE !== 1'b1 || FIFOADR !== 2'b10) begin
                errors++;
                $display("FAIL usb_stall strobes got slwr=%b sloe=%b adr=%b want 1/1/10", SLWR, SLOE, FIFOADR);
            end
            checks++;
            if (FDATA !== exp_res[15:0]) begin
                errors++;
                $display("FAIL usb_stall fdata got %h want %h", FDATA, exp_res[15:0]);
            end
        end
        FLAGD = 1'b0;
        run_and_check(base, "usb_stall");
    endtask

    task automatic test_back_to_back();
        int base;
        stall_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            base = n_stream;
            push_random_frame();
            push_random_frame();
            run_and_check(base, "b2b_a");
            run_and_check(base + 2 * N_TAPS, "b2b_b");
        end
        stall_rand = 1'b0;
    endtask

    task automatic test_slots();
        int base;
        while (frames_done < N_SLOTS + 1) begin
            base = n_stream;
            push_random_frame();
            run_and_check(base, "slots");
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = n_stream;
        push_random_frame();
        for (int c = 0; c < 300; c++) begin
            if (cstate == 4'd4) break;
            @(negedge CLK);
        end
        checks++;
        if (cstate !== 4'd4 || cyc_i !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid reach_wb got st=%0d cyc=%b want 4/1", cstate, cyc_i);
        end
        rst_n = 1'b1;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge CLK);
        rst_n = 1'b0;
        exp_slot = 0;
        base = n_stream;
        push_random_frame();
        run_and_check(base, "after_reset");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_flaga_stall();
        test_signed();
        test_usb_stall();
        test_back_to_back();
        test_slots();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
